// File: rtl/mdu_unit.sv
// mdu_unit: E-stage multiply/divide unit that owns the HI/LO registers.
//
// Operations are issued through a start/busy handshake. An accepted MULT/MULTU/DIV/DIVU
// computes its result at issue into pending registers. It then holds busy for
// MULT_CYCLES or DIV_CYCLES cycles before committing to HI/LO. While busy, every command
// is ignored, so the hazard unit must stall MDU instructions on (busy | start).
//
// Optional feature: define MDU_MADD_EN to decode MADD (8), MADDU (9), MSUB (10) and
// MSUBU (11). These accumulate into {hi,lo}. When it is undefined, ops 8-15 are NOOPs.
//
// Ports:
//   clk            rising-edge clock
//   reset_n        synchronous active-low reset; clears HI/LO and drops any in-flight op
//   MDU_Operation  command: 0 NOOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 READ
//   op_valid       E-stage instruction is real
//   flush          exception taken this cycle; suppresses issue
//   rs_data        operand A
//   rt_data        operand B
//   start          combinational; a mult/div is accepted this cycle
//   busy           registered; an operation is in flight
//   hi, lo         committed HI/LO
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  MDU_Operation,
    input  logic        op_valid,
    input  logic        flush,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [3:0] OpMult  = 4'd1;
    localparam logic [3:0] OpMultu = 4'd2;
    localparam logic [3:0] OpDiv   = 4'd3;
    localparam logic [3:0] OpDivu  = 4'd4;
    localparam logic [3:0] OpMthi  = 4'd5;
    localparam logic [3:0] OpMtlo  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OpMadd  = 4'd8;
    localparam logic [3:0] OpMaddu = 4'd9;
    localparam logic [3:0] OpMsub  = 4'd10;
    localparam logic [3:0] OpMsubu = 4'd11;
`endif

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;

    logic        accept;
    logic        is_md;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_zero;
    logic [31:0] dvsr_u;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] quo_u;
    logic [31:0] rem_u;

    assign accept = op_valid & ~flush & (state_q == StIdle);
    assign busy   = (state_q == StRun);
    assign hi     = hi_q;
    assign lo     = lo_q;

    // The low 64 bits of a product of sign-extended operands equal the signed product.
    assign prod_s = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
    assign prod_u = {32'd0, rs_data} * {32'd0, rt_data};

    // Substitute a divisor of 1 for zero so that the dividers never produce X.
    // The result is discarded in that case.
    assign div_zero = (rt_data == 32'd0);
    assign dvsr_u   = div_zero ? 32'd1 : rt_data;
    assign quo_u    = rs_data / dvsr_u;
    assign rem_u    = rs_data % dvsr_u;

    // Signed divide on magnitudes. The quotient is truncated toward zero and the remainder
    // takes the dividend's sign. 0x80000000 / -1 gives 0x80000000 with no special case.
    assign abs_a = rs_data[31] ? (32'd0 - rs_data) : rs_data;
    assign abs_b = rt_data[31] ? (32'd0 - dvsr_u) : dvsr_u;
    assign mag_q = abs_a / abs_b;
    assign mag_r = abs_a % abs_b;
    assign quo_s = (rs_data[31] ^ rt_data[31]) ? (32'd0 - mag_q) : mag_q;
    assign rem_s = rs_data[31] ? (32'd0 - mag_r) : mag_r;

    always_comb begin
        is_md = 1'b0;
        case (MDU_Operation)
            OpMult, OpMultu, OpDiv, OpDivu: is_md = 1'b1;
`ifdef MDU_MADD_EN
            OpMadd, OpMaddu, OpMsub, OpMsubu: is_md = 1'b1;
`endif
            default: is_md = 1'b0;
        endcase
    end

    assign start = accept & is_md;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    case (MDU_Operation)
                        OpMult: begin
                            {pend_hi_d, pend_lo_d} = prod_s;
                            cnt_d   = MULT_CYCLES;
                            state_d = StRun;
                        end
                        OpMultu: begin
                            {pend_hi_d, pend_lo_d} = prod_u;
                            cnt_d   = MULT_CYCLES;
                            state_d = StRun;
                        end
                        OpDiv: begin
                            // A divide by zero commits the current HI/LO back unchanged.
                            if (div_zero) begin
                                pend_hi_d = hi_q;
                                pend_lo_d = lo_q;
                            end else begin
                                pend_hi_d = rem_s;
                                pend_lo_d = quo_s;
                            end
                            cnt_d   = DIV_CYCLES;
                            state_d = StRun;
                        end
                        OpDivu: begin
                            if (div_zero) begin
                                pend_hi_d = hi_q;
                                pend_lo_d = lo_q;
                            end else begin
                                pend_hi_d = rem_u;
                                pend_lo_d = quo_u;
                            end
                            cnt_d   = DIV_CYCLES;
                            state_d = StRun;
                        end
                        OpMthi: hi_d = rs_data;
                        OpMtlo: lo_d = rs_data;
`ifdef MDU_MADD_EN
                        OpMadd: begin
                            {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_s;
                            cnt_d   = MULT_CYCLES;
                            state_d = StRun;
                        end
                        OpMaddu: begin
                            {pend_hi_d, pend_lo_d} = {hi_q, lo_q} + prod_u;
                            cnt_d   = MULT_CYCLES;
                            state_d = StRun;
                        end
                        OpMsub: begin
                            {pend_hi_d, pend_lo_d} = {hi_q, lo_q} - prod_s;
                            cnt_d   = MULT_CYCLES;
                            state_d = StRun;
                        end
                        OpMsubu: begin
                            {pend_hi_d, pend_lo_d} = {hi_q, lo_q} - prod_u;
                            cnt_d   = MULT_CYCLES;
                            state_d = StRun;
                        end
`endif
                        default: ;
                    endcase
                end
            end
            StRun: begin
                cnt_d = cnt_q - 32'd1;
                if (cnt_q == 32'd1) begin
                    hi_d    = pend_hi_q;
                    lo_d    = pend_lo_q;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            cnt_q     <= 32'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
        end
    end

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed table-driven bench for mdu_unit, plus hand-written sequences
// for the busy-time ignore, flush-during-run and reset-during-run cases.
module tb_mdu_unit;

    logic        clk;
    logic        reset_n;
    logic [3:0]  MDU_Operation;
    logic        op_valid;
    logic        flush;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        start;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks;
    int n_fail;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    mdu_unit #(
        .MULT_CYCLES(5),
        .DIV_CYCLES (10)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .MDU_Operation(MDU_Operation),
        .op_valid     (op_valid),
        .flush        (flush),
        .rs_data      (rs_data),
        .rt_data      (rt_data),
        .start        (start),
        .busy         (busy),
        .hi           (hi),
        .lo           (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        bit          valid;
        bit          fl;
        logic [31:0] a;
        logic [31:0] b;
        bit          exp_start;
        int          exp_busy;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string n, input logic [3:0] op, input bit valid, input bit fl,
                       input logic [31:0] a, input logic [31:0] b, input bit st,
                       input int nb, input logic [31:0] eh, input logic [31:0] el);
        vec_t v;
        v.name = n; v.op = op; v.valid = valid; v.fl = fl; v.a = a; v.b = b;
        v.exp_start = st; v.exp_busy = nb; v.exp_hi = eh; v.exp_lo = el;
        vq.push_back(v);
    endtask

    task automatic chk32(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", n, act, exp);
        end
    endtask

    task automatic chk_int(input string n, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", n, act, exp);
        end
    endtask

    task automatic chk1(input string n, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, want %b", n, act, exp);
        end
    endtask

    task automatic idle_inputs();
        MDU_Operation = 4'd0;
        op_valid      = 1'b0;
        flush         = 1'b0;
        rs_data       = 32'd0;
        rt_data       = 32'd0;
    endtask

    // Count busy cycles from the current negedge on. On return, the bench sits at the first
    // negedge with busy low. HI/LO must hold the old committed values while busy.
    task automatic wait_idle(input string n, output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            chk32({n, "_hi_hold"}, hi, cur_hi);
            chk32({n, "_lo_hold"}, lo, cur_lo);
            cnt++;
            @(negedge clk);
        end
    endtask

    task automatic run_vec(input vec_t v);
        int nb;
        @(negedge clk);
        MDU_Operation = v.op;
        op_valid      = v.valid;
        flush         = v.fl;
        rs_data       = v.a;
        rt_data       = v.b;
        #1;
        chk1({v.name, "_start"}, start, v.exp_start);
        @(negedge clk);
        idle_inputs();
        wait_idle(v.name, nb);
        chk_int({v.name, "_busy_cycles"}, nb, v.exp_busy);
        chk32({v.name, "_hi"}, hi, v.exp_hi);
        chk32({v.name, "_lo"}, lo, v.exp_lo);
        cur_hi = v.exp_hi;
        cur_lo = v.exp_lo;
    endtask

    initial begin
        int nb;
        n_checks = 0;
        n_fail   = 0;
        cur_hi   = 32'd0;
        cur_lo   = 32'd0;
        idle_inputs();
        reset_n = 1'b0;

        add("valid0_mult",   4'd1,  1'b0, 1'b0, 32'd5,        32'd5,        1'b0, 0,
            32'h0,        32'h0);
        add("mult_neg2x3",   4'd1,  1'b1, 1'b0, 32'hFFFFFFFE, 32'd3,        1'b1, 5,
            32'hFFFFFFFF, 32'hFFFFFFFA);
        add("multu_max",     4'd2,  1'b1, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 5,
            32'hFFFFFFFE, 32'h00000001);
        add("div_m7_2",      4'd3,  1'b1, 1'b0, 32'hFFFFFFF9, 32'd2,        1'b1, 10,
            32'hFFFFFFFF, 32'hFFFFFFFD);
        add("divu_by0",      4'd4,  1'b1, 1'b0, 32'd7,        32'd0,        1'b1, 10,
            32'hFFFFFFFF, 32'hFFFFFFFD);
        add("mtlo_flush",    4'd6,  1'b1, 1'b1, 32'h55,       32'd0,        1'b0, 0,
            32'hFFFFFFFF, 32'hFFFFFFFD);
        add("mtlo",          4'd6,  1'b1, 1'b0, 32'h55,       32'd0,        1'b0, 0,
            32'hFFFFFFFF, 32'h00000055);
        add("mthi",          4'd5,  1'b1, 1'b0, 32'h1234,     32'd0,        1'b0, 0,
            32'h00001234, 32'h00000055);
        add("read",          4'd7,  1'b1, 1'b0, 32'hAAAA,     32'hBBBB,     1'b0, 0,
            32'h00001234, 32'h00000055);
        add("op15_noop",     4'd15, 1'b1, 1'b0, 32'hAAAA,     32'hBBBB,     1'b0, 0,
            32'h00001234, 32'h00000055);
        add("div_ovf",       4'd3,  1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 1'b1, 10,
            32'h00000000, 32'h80000000);
        add("divu_100_7",    4'd4,  1'b1, 1'b0, 32'd100,      32'd7,        1'b1, 10,
            32'h00000002, 32'h0000000E);
        add("div_7_m2",      4'd3,  1'b1, 1'b0, 32'd7,        32'hFFFFFFFE, 1'b1, 10,
            32'h00000001, 32'hFFFFFFFD);
        add("mult_7_m3",     4'd1,  1'b1, 1'b0, 32'd7,        32'hFFFFFFFD, 1'b1, 5,
            32'hFFFFFFFF, 32'hFFFFFFEB);
        add("mthi_0",        4'd5,  1'b1, 1'b0, 32'd0,        32'd0,        1'b0, 0,
            32'h00000000, 32'hFFFFFFEB);
        add("mtlo_ones",     4'd6,  1'b1, 1'b0, 32'hFFFFFFFF, 32'd0,        1'b0, 0,
            32'h00000000, 32'hFFFFFFFF);
`ifdef MDU_MADD_EN
        add("maddu_1x1",     4'd9,  1'b1, 1'b0, 32'd1,        32'd1,        1'b1, 5,
            32'h00000001, 32'h00000000);
`else
        add("op9_noop",      4'd9,  1'b1, 1'b0, 32'd1,        32'd1,        1'b0, 0,
            32'h00000000, 32'hFFFFFFFF);
`endif

        // Reset state
        repeat (3) @(negedge clk);
        chk1("rst_busy", busy, 1'b0);
        chk32("rst_hi", hi, 32'd0);
        chk32("rst_lo", lo, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        chk1("rst_start", start, 1'b0);

        foreach (vq[i]) run_vec(vq[i]);

        // MTHI issued while a MULT is busy is ignored.
        @(negedge clk);
        MDU_Operation = 4'd1; op_valid = 1'b1; rs_data = 32'd2; rt_data = 32'd3;
        @(negedge clk);                                   // T+1
        idle_inputs();
        @(negedge clk);                                   // T+2
        MDU_Operation = 4'd5; op_valid = 1'b1; rs_data = 32'h1234;
        #1;
        chk1("busy_mthi_start", start, 1'b0);
        chk1("busy_mthi_busy", busy, 1'b1);
        @(negedge clk);                                   // T+3
        idle_inputs();
        wait_idle("busy_mthi", nb);
        chk_int("busy_mthi_cycles", nb, 3);
        chk32("busy_mthi_hi", hi, 32'd0);
        chk32("busy_mthi_lo", lo, 32'd6);
        cur_hi = 32'd0;
        cur_lo = 32'd6;

        // A flush in the middle of a DIV does not cancel it.
        @(negedge clk);                                   // T
        MDU_Operation = 4'd3; op_valid = 1'b1; rs_data = 32'd20; rt_data = 32'd3;
        @(negedge clk);                                   // T+1
        idle_inputs();
        @(negedge clk);                                   // T+2
        @(negedge clk);                                   // T+3
        flush = 1'b1; op_valid = 1'b1; MDU_Operation = 4'd6; rs_data = 32'h77;
        #1;
        chk1("flush_run_start", start, 1'b0);
        @(negedge clk);                                   // T+4
        idle_inputs();
        wait_idle("flush_run", nb);
        chk_int("flush_run_cycles", nb, 7);
        chk32("flush_run_hi", hi, 32'd2);
        chk32("flush_run_lo", lo, 32'd6);

        // A reset in the middle of a DIV drops it.
        @(negedge clk);                                   // T
        MDU_Operation = 4'd4; op_valid = 1'b1; rs_data = 32'd100; rt_data = 32'd7;
        @(negedge clk);                                   // T+1
        idle_inputs();
        repeat (3) @(negedge clk);                        // T+4
        reset_n = 1'b0;
        @(negedge clk);                                   // T+5
        chk1("rst_run_busy", busy, 1'b0);
        chk32("rst_run_hi", hi, 32'd0);
        chk32("rst_run_lo", lo, 32'd0);
        reset_n = 1'b1;
        repeat (15) @(negedge clk);
        chk1("rst_run_busy_late", busy, 1'b0);
        chk32("rst_run_hi_late", hi, 32'd0);
        chk32("rst_run_lo_late", lo, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in stage E. Executes the MDU_Operation command produced by the instruction decoder and owns the HI/LO registers.
- Models multi-cycle latency through a busy/start handshake. The hazard unit uses these signals to stall any later MDU instruction.
- Supplies HI/LO to the E-stage result mux for MFHI/MFLO.

Parameters:
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (must be ≥1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (must be ≥1).

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  synchronous, active-low reset.
- MDU_Operation  input  4  command. 0 NOOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 READ; 8–15 are treated as NOOP.
- op_valid  input  1  the E-stage instruction is real (not a bubble).
- flush  input  1  exception/interrupt taken this cycle; suppresses issue.
- rs_data  input  32  operand A, forwarded.
- rt_data  input  32  operand B, forwarded.
- start  output  1  combinational; a MULT/MULTU/DIV/DIVU is accepted this cycle.
- busy  output  1  registered; an operation is in flight.
- hi  output  32  committed HI.
- lo  output  32  committed LO.

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - hi=0, lo=0, busy=0, counter=0, pending regs=0.
  - Any in-flight operation is discarded.
  - Reset dominates every other input.
- Accept condition: `accept = op_valid & ~flush & ~busy`.
- start = accept & (op ∈ {1,2,3,4}). start is combinational and never asserted while busy=1.
- States:
  - IDLE (busy=0):
    - On accept with a mult/div op: latch the result into pend_hi/pend_lo, load counter with MULT_CYCLES or DIV_CYCLES, go to RUN.
    - MTHI/MTLO on accept: hi<=rs_data or lo<=rs_data at that edge. Stay in IDLE.
    - READ and NOOP change nothing.
  - RUN (busy=1):
    - Counter decrements each cycle.
    - On the cycle with counter==1: hi<=pend_hi, lo<=pend_lo, busy<=0, go to IDLE.
- Latency: for an op accepted in cycle T, busy=1 in cycles T+1..T+N and new hi/lo are visible from T+N+1. N=MULT_CYCLES or DIV_CYCLES.
- While busy, every command is ignored, including MTHI/MTLO/READ. The hazard unit must stall any MDU instruction when `busy|start`.
- hi/lo outputs always show committed values. The pending result is never visible early.
- Arithmetic:
  - MULT: {hi,lo} = signed 32×32 → 64.
  - MULTU: {hi,lo} = unsigned 32×32 → 64.
  - DIV: lo = signed quotient truncated toward zero; hi = remainder with the sign of the dividend.
  - DIVU: lo = unsigned quotient; hi = unsigned remainder.
- Boundaries:
  - Divide by zero (rt_data=0): the op still runs DIV_CYCLES with busy; hi/lo stay unchanged at completion.
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- Flush:
  - Flush in the issue cycle suppresses accept. No start, and no MTHI/MTLO write.
  - Flush during RUN does not cancel the in-flight op. The op completes and commits normally, because it was already issued.
- op_valid=0 behaves as NOOP.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: ops 8 MADD, 9 MADDU, 10 MSUB, 11 MSUBU are decoded.
  - Pend = {hi,lo} ± product (signed or unsigned product, per op), modulo 2^64.
  - Latency is MULT_CYCLES.
  - The accumulator is sampled at accept.
- Undefined: ops 8–15 are NOOP (start=0, no state change).

Test Plan:
- Reset then MULT rs=0xFFFFFFFE, rt=3 with op_valid=1 → start=1 in cycle T; busy=1 for T+1..T+5; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. hi/lo hold 0 before that.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → after 5 busy cycles, hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7/2 → after 10 busy cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 7/0 → busy 10 cycles, hi/lo unchanged.
- MTHI 0x1234 while busy → ignored, no write. MTLO 0x55 with flush=1 in IDLE → lo unchanged. MTLO 0x55 with flush=0 → lo=0x55 next cycle, busy stays 0.
- DIV started, flush asserted at T+3 → result still commits at T+10. DIV started, reset_n=0 at T+4 → busy=0, hi=lo=0 next cycle, no later commit.
- With MDU_MADD_EN: hi=0, lo=0xFFFFFFFF, then MADDU 1×1 → hi=1, lo=0. Without the macro, op 9 → start=0 and hi/lo unchanged.
